// File: rtl/matrix_host_bridge.sv
// matrix_host_bridge: lightweight-bridge word-port slave that feeds the matrix
// coprocessor. The host moves elements with a 4-phase req/ack handshake.
// Optional watchdog: define MATRIX_BRIDGE_TIMEOUT_EN to bound the PROCESS wait.
module matrix_host_bridge #(
  parameter int ELEM_W         = 8,
  parameter int MAX_DIM        = 5,
  parameter int IDX_W          = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [31:0]                       data_in,
  output logic [31:0]                       data_out,
  output logic                              cop_start,
  output logic [2:0]                        cop_op,
  output logic [1:0]                        cop_size,
  output logic [ELEM_W*MAX_DIM*MAX_DIM-1:0] cop_a_flat,
  output logic [ELEM_W*MAX_DIM*MAX_DIM-1:0] cop_b_flat,
  input  logic [ELEM_W*MAX_DIM*MAX_DIM-1:0] cop_result_flat,
  input  logic                              cop_done
);

  localparam int FLAT_W = ELEM_W * MAX_DIM * MAX_DIM;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECEIVE = 3'd1,
    PROCESS = 3'd2,
    SEND    = 3'd3,
    ERROR   = 3'd4
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  index;
  logic [IDX_W-1:0]  count_m1;
  logic              ack;
  logic              error;
  logic [ELEM_W-1:0] res_out;
  logic [FLAT_W-1:0] a_mem;
  logic [FLAT_W-1:0] b_mem;
  logic [FLAT_W-1:0] res_mem;

  logic req_meta;
  logic req_s;
  logic req_d;
  logic req_rise;
  logic req_fall;
  logic abort;
  logic start;
  logic busy;
  logic [4:0] dim_n;
  logic [4:0] dim_sq_m1;
  logic unused_in;

  assign abort     = data_in[29];
  assign start     = data_in[30];
  assign req_rise  = req_s & ~req_d;
  assign req_fall  = ~req_s & req_d;
  assign dim_n     = {3'b000, data_in[20:19]} + 5'd2;
  assign dim_sq_m1 = dim_n * dim_n - 5'd1;
  assign busy      = (state != IDLE) && (state != ERROR);
  assign unused_in = ^{data_in[28:21], data_in[15:0]};

  assign cop_a_flat = a_mem;
  assign cop_b_flat = b_mem;

`ifdef MATRIX_BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] timeout_cnt;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  // Two-flop synchroniser for the host req line plus a delayed copy for edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_meta <= 1'b0;
      req_s    <= 1'b0;
      req_d    <= 1'b0;
    end else begin
      req_meta <= data_in[31];
      req_s    <= req_meta;
      req_d    <= req_s;
    end
  end

  // Main controller: abort first, then per-state handshake and coprocessor flow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      index     <= '0;
      count_m1  <= '0;
      ack       <= 1'b0;
      error     <= 1'b0;
      res_out   <= '0;
      cop_start <= 1'b0;
      cop_op    <= 3'd0;
      cop_size  <= 2'd0;
      a_mem     <= '0;
      b_mem     <= '0;
      res_mem   <= '0;
`ifdef MATRIX_BRIDGE_TIMEOUT_EN
      timeout_cnt <= '0;
`endif
    end else begin
      cop_start <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        index   <= '0;
        ack     <= 1'b0;
        error   <= 1'b0;
        res_out <= '0;
      end else begin
        case (state)
          IDLE: begin
            ack <= 1'b0;
            if (start && !req_s) begin
              cop_op   <= data_in[18:16];
              cop_size <= data_in[20:19];
              count_m1 <= IDX_W'(dim_sq_m1);
              a_mem    <= '0;
              b_mem    <= '0;
              index    <= '0;
              if (int'(dim_n) > MAX_DIM) begin
                state <= ERROR;
                error <= 1'b1;
              end else begin
                state <= RECEIVE;
              end
            end
          end
          RECEIVE: begin
            if (req_rise && !ack) begin
              a_mem[index*ELEM_W +: ELEM_W] <= data_in[ELEM_W-1:0];
              b_mem[index*ELEM_W +: ELEM_W] <= data_in[8 +: ELEM_W];
              ack <= 1'b1;
            end else if (req_fall && ack) begin
              ack <= 1'b0;
              if (index == count_m1) begin
                state     <= PROCESS;
                index     <= '0;
                cop_start <= 1'b1;
`ifdef MATRIX_BRIDGE_TIMEOUT_EN
                timeout_cnt <= '0;
`endif
              end else begin
                index <= index + 1'b1;
              end
            end
          end
          PROCESS: begin
            if (cop_done) begin
              res_mem <= cop_result_flat;
              res_out <= cop_result_flat[ELEM_W-1:0];
              state   <= SEND;
              index   <= '0;
            end
`ifdef MATRIX_BRIDGE_TIMEOUT_EN
            else if (timeout_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
              state <= ERROR;
              error <= 1'b1;
            end else begin
              timeout_cnt <= timeout_cnt + 1'b1;
            end
`endif
          end
          SEND: begin
            if (req_rise && !ack) begin
              ack <= 1'b1;
            end else if (req_fall && ack) begin
              ack <= 1'b0;
              if (index == count_m1) begin
                state   <= IDLE;
                index   <= '0;
                res_out <= '0;
              end else begin
                index   <= index + 1'b1;
                res_out <= res_mem[(index + 1'b1)*ELEM_W +: ELEM_W];
              end
            end
          end
          ERROR: begin
            ack   <= 1'b0;
            error <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Status word assembled purely from registered state
  always_comb begin
    data_out                = '0;
    data_out[31]            = ack;
    data_out[30]            = busy;
    data_out[29]            = error;
    data_out[28:26]         = state;
    data_out[20:16]         = 5'(index);
    data_out[ELEM_W-1:0]    = res_out;
  end

endmodule

// File: tb/tb_matrix_host_bridge.sv
// tb_matrix_host_bridge: randomized self-checking bench for matrix_host_bridge.
// Main instance uses default geometry; a second MAX_DIM=3 instance covers the
// oversize error path. Honors MATRIX_BRIDGE_TIMEOUT_EN for the watchdog case.
module tb_matrix_host_bridge;

  localparam int W   = 8;
  localparam int N   = 25;
  localparam int FW  = W * N;
  localparam int FWS = W * 9;
  localparam int TO  = 16;

  logic clk = 1'b0;
  logic reset_n;

  logic [31:0]  data_in, data_out;
  logic         cop_start, cop_done;
  logic [2:0]   cop_op;
  logic [1:0]   cop_size;
  logic [FW-1:0] cop_a_flat, cop_b_flat, cop_result_flat;

  logic [31:0]   data_in_s, data_out_s;
  logic          cop_start_s, cop_done_s;
  logic [2:0]    cop_op_s;
  logic [1:0]    cop_size_s;
  logic [FWS-1:0] cop_a_flat_s, cop_b_flat_s, cop_result_flat_s;

  int tests_run = 0;
  int tests_failed = 0;
  int start_cycles = 0;
  logic cop_auto;
  int cop_delay;

  logic [7:0] model_a [N];
  logic [7:0] model_b [N];
  logic [7:0] model_r [N];
  logic [7:0] got_r   [N];

  matrix_host_bridge #(.ELEM_W(W), .MAX_DIM(5), .IDX_W(5), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_out(data_out),
    .cop_start(cop_start), .cop_op(cop_op), .cop_size(cop_size),
    .cop_a_flat(cop_a_flat), .cop_b_flat(cop_b_flat),
    .cop_result_flat(cop_result_flat), .cop_done(cop_done)
  );

  matrix_host_bridge #(.ELEM_W(W), .MAX_DIM(3), .IDX_W(4), .TIMEOUT_CYCLES(TO)) dut_small (
    .clk(clk), .reset_n(reset_n), .data_in(data_in_s), .data_out(data_out_s),
    .cop_start(cop_start_s), .cop_op(cop_op_s), .cop_size(cop_size_s),
    .cop_a_flat(cop_a_flat_s), .cop_b_flat(cop_b_flat_s),
    .cop_result_flat(cop_result_flat_s), .cop_done(cop_done_s)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Coprocessor result bus mirrors the bench's chosen result matrix
  always_comb begin
    cop_result_flat = '0;
    for (int i = 0; i < N; i++) cop_result_flat[i*W +: W] = model_r[i];
  end

  // Count every cycle cop_start is high, sampled away from the active edge
  always @(negedge clk) begin
    if (cop_start === 1'b1) start_cycles++;
  end

  // Coprocessor model: answers cop_start with a done pulse after cop_delay clocks
  initial begin
    cop_done = 1'b0;
    forever begin
      @(negedge clk);
      if (cop_start === 1'b1 && cop_auto) begin
        repeat (cop_delay) @(negedge clk);
        cop_done = 1'b1;
        @(negedge clk);
        cop_done = 1'b0;
      end
    end
  end

  function automatic logic [31:0] cmd(input logic req, input logic start, input logic abort,
                                      input logic [1:0] size, input logic [2:0] op,
                                      input logic [7:0] b, input logic [7:0] a);
    return {req, start, abort, 8'h00, size, op, b, a};
  endfunction

  function automatic logic [FW-1:0] pack_arr(input logic [7:0] arr [N], input int cnt);
    logic [FW-1:0] v = '0;
    for (int i = 0; i < cnt; i++) v[i*W +: W] = arr[i];
    return v;
  endfunction

  task automatic randomize_model();
    for (int i = 0; i < N; i++) begin
      model_a[i] = 8'($urandom);
      model_b[i] = 8'($urandom);
      model_r[i] = 8'($urandom);
    end
  endtask

  task automatic wait_ack(input logic level, output int lat);
    lat = 99;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (data_out[31] === level) begin lat = k; break; end
    end
  endtask

  task automatic handshake(input logic [7:0] a, input logic [7:0] b,
                           output int rlat, output int flat, output logic [31:0] sample);
    data_in = cmd(1'b1, 1'b0, 1'b0, 2'($urandom), 3'($urandom), b, a);
    wait_ack(1'b1, rlat);
    sample = data_out;
    data_in = cmd(1'b0, 1'b0, 1'b0, 2'($urandom), 3'($urandom), b, a);
    wait_ack(1'b0, flat);
  endtask

  task automatic push_elements(input int first, input int cnt, output int lat_bad);
    int r, f; logic [31:0] s;
    lat_bad = 0;
    for (int i = first; i < first + cnt; i++) begin
      handshake(model_a[i], model_b[i], r, f, s);
      if (r != 3 || f != 3) lat_bad++;
    end
  endtask

  task automatic pull_results(input int cnt, output int lat_bad, output int idx_bad);
    int r, f; logic [31:0] s;
    lat_bad = 0; idx_bad = 0;
    for (int i = 0; i < N; i++) got_r[i] = 8'h00;
    for (int i = 0; i < cnt; i++) begin
      handshake(8'($urandom), 8'($urandom), r, f, s);
      got_r[i] = s[7:0];
      if (r != 3 || f != 3) lat_bad++;
      if (s[20:16] !== 5'(i)) idx_bad++;
    end
  endtask

  task automatic do_start(input logic [2:0] op, input logic [1:0] size);
    data_in = cmd(1'b0, 1'b1, 1'b0, size, op, 8'h00, 8'h00);
    @(posedge clk); #1;
    data_in = 32'h0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, output int cyc);
    cyc = -1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      if (data_out[28:26] === s) begin cyc = k; break; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (data_out !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_data_out: got %h want %h", data_out, 32'h0); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (data_out !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_release_data_out: got %h want %h", data_out, 32'h0); end
    tests_run++; if ({cop_start, cop_op, cop_size} !== 6'd0) begin tests_failed++; $display("[TB] FAIL reset_cop_ctrl: got %b want 0", {cop_start, cop_op, cop_size}); end
    tests_run++; if ((cop_a_flat | cop_b_flat) !== '0) begin tests_failed++; $display("[TB] FAIL reset_storage: got %h want 0", cop_a_flat | cop_b_flat); end
  endtask

  task automatic test_basic();
    int lb, ib, cyc, s0;
    randomize_model();
    for (int i = 0; i < 4; i++) begin
      model_a[i] = 8'(i + 1);
      model_b[i] = 8'(i + 5);
    end
    cop_auto = 1'b1; cop_delay = 10; s0 = start_cycles;
    do_start(3'd3, 2'd0);
    tests_run++; if (data_out[30:26] !== 5'b10001) begin tests_failed++; $display("[TB] FAIL basic_receive_state: got %b want %b", data_out[30:26], 5'b10001); end
    tests_run++; if ({cop_op, cop_size} !== 5'b01100) begin tests_failed++; $display("[TB] FAIL basic_latch_op_size: got %b want %b", {cop_op, cop_size}, 5'b01100); end
    push_elements(0, 4, lb);
    tests_run++; if (lb !== 0) begin tests_failed++; $display("[TB] FAIL basic_ack_latency: got %0d bad handshakes want 0", lb); end
    tests_run++; if (data_out[28:26] !== 3'd2) begin tests_failed++; $display("[TB] FAIL basic_process_state: got %0d want 2", data_out[28:26]); end
    wait_state(3'd3, 40, cyc);
    tests_run++; if (cyc < 0) begin tests_failed++; $display("[TB] FAIL basic_send_entry: got state %0d want 3", data_out[28:26]); end
    tests_run++; if (cop_a_flat !== {{(FW-32){1'b0}}, 32'h04030201}) begin tests_failed++; $display("[TB] FAIL basic_a_flat: got %h want %h", cop_a_flat, {{(FW-32){1'b0}}, 32'h04030201}); end
    tests_run++; if (cop_b_flat !== {{(FW-32){1'b0}}, 32'h08070605}) begin tests_failed++; $display("[TB] FAIL basic_b_flat: got %h want %h", cop_b_flat, {{(FW-32){1'b0}}, 32'h08070605}); end
    tests_run++; if (start_cycles - s0 !== 1) begin tests_failed++; $display("[TB] FAIL basic_start_pulse: got %0d cycles want 1", start_cycles - s0); end
    pull_results(4, lb, ib);
    tests_run++; if (pack_arr(got_r, 4) !== pack_arr(model_r, 4)) begin tests_failed++; $display("[TB] FAIL basic_results: got %h want %h", pack_arr(got_r, 4), pack_arr(model_r, 4)); end
    tests_run++; if (lb !== 0 || ib !== 0) begin tests_failed++; $display("[TB] FAIL basic_send_handshake: got lat_bad=%0d idx_bad=%0d want 0/0", lb, ib); end
    tests_run++; if (data_out[30:26] !== 5'b00000) begin tests_failed++; $display("[TB] FAIL basic_back_to_idle: got %b want 0", data_out[30:26]); end
  endtask

  task automatic test_full_size();
    int lb, ib, cyc, s0;
    randomize_model();
    cop_auto = 1'b1; cop_delay = 12;
    do_start(3'($urandom), 2'd3);
    s0 = start_cycles;
    push_elements(0, 24, lb);
    tests_run++; if (start_cycles - s0 !== 0 || data_out[28:26] !== 3'd1) begin tests_failed++; $display("[TB] FAIL full_24_no_start: got starts=%0d state=%0d want 0/1", start_cycles - s0, data_out[28:26]); end
    push_elements(24, 1, ib);
    tests_run++; if (lb + ib !== 0) begin tests_failed++; $display("[TB] FAIL full_ack_latency: got %0d bad want 0", lb + ib); end
    tests_run++; if (data_out[28:26] !== 3'd2) begin tests_failed++; $display("[TB] FAIL full_process_after_25: got %0d want 2", data_out[28:26]); end
    data_in = cmd(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 8'hAA, 8'h55);
    repeat (5) @(posedge clk);
    #1;
    tests_run++; if (data_out[31] !== 1'b0 || data_out[28:26] !== 3'd2) begin tests_failed++; $display("[TB] FAIL full_26th_req_ignored: got ack=%b state=%0d want 0/2", data_out[31], data_out[28:26]); end
    data_in = 32'h0;
    wait_state(3'd3, 40, cyc);
    tests_run++; if (cyc < 0) begin tests_failed++; $display("[TB] FAIL full_send_entry: got state %0d want 3", data_out[28:26]); end
    tests_run++; if (cop_a_flat !== pack_arr(model_a, N) || cop_b_flat !== pack_arr(model_b, N)) begin tests_failed++; $display("[TB] FAIL full_ab_flat: got a=%h want a=%h", cop_a_flat, pack_arr(model_a, N)); end
    tests_run++; if (start_cycles - s0 !== 1) begin tests_failed++; $display("[TB] FAIL full_start_pulse: got %0d want 1", start_cycles - s0); end
    pull_results(N, lb, ib);
    tests_run++; if (pack_arr(got_r, N) !== pack_arr(model_r, N) || lb !== 0 || ib !== 0) begin tests_failed++; $display("[TB] FAIL full_results: got %h (lat_bad=%0d idx_bad=%0d) want %h", pack_arr(got_r, N), lb, ib, pack_arr(model_r, N)); end
    tests_run++; if (data_out[28:26] !== 3'd0) begin tests_failed++; $display("[TB] FAIL full_back_to_idle: got %0d want 0", data_out[28:26]); end
  endtask

  task automatic test_abort();
    int lb, ib, cyc;
    randomize_model();
    cop_auto = 1'b1; cop_delay = 4;
    do_start(3'($urandom), 2'd3);
    push_elements(0, 7, lb);
    tests_run++; if (data_out[20:16] !== 5'd7 || lb !== 0) begin tests_failed++; $display("[TB] FAIL abort_pre_index: got idx=%0d lat_bad=%0d want 7/0", data_out[20:16], lb); end
    data_in = cmd(1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 8'h00, 8'h00);
    @(posedge clk); #1;
    data_in = 32'h0;
    tests_run++; if (data_out[31:16] !== 16'h0) begin tests_failed++; $display("[TB] FAIL abort_status: got %h want 0000", data_out[31:16]); end
    tests_run++; if (cop_a_flat !== pack_arr(model_a, 7) || cop_size !== 2'd3) begin tests_failed++; $display("[TB] FAIL abort_storage_held: got a=%h size=%0d want a=%h size=3", cop_a_flat, cop_size, pack_arr(model_a, 7)); end
    randomize_model();
    do_start(3'($urandom), 2'd1);
    push_elements(0, 9, lb);
    tests_run++; if (data_out[28:26] !== 3'd2 || lb !== 0) begin tests_failed++; $display("[TB] FAIL abort_restart_9: got state=%0d lat_bad=%0d want 2/0", data_out[28:26], lb); end
    tests_run++; if (cop_a_flat !== pack_arr(model_a, 9) || cop_b_flat !== pack_arr(model_b, 9)) begin tests_failed++; $display("[TB] FAIL abort_restart_flat: got %h want %h", cop_a_flat, pack_arr(model_a, 9)); end
    wait_state(3'd3, 40, cyc);
    pull_results(9, lb, ib);
    tests_run++; if (cyc < 0 || pack_arr(got_r, 9) !== pack_arr(model_r, 9) || ib !== 0) begin tests_failed++; $display("[TB] FAIL abort_restart_results: got %h (cyc=%0d idx_bad=%0d) want %h", pack_arr(got_r, 9), cyc, ib, pack_arr(model_r, 9)); end
  endtask

  task automatic test_oversize_error();
    int acks;
    data_in_s = cmd(1'b0, 1'b1, 1'b0, 2'd2, 3'd5, 8'h00, 8'h00);
    @(posedge clk); #1;
    data_in_s = 32'h0;
    tests_run++; if (data_out_s[30:26] !== 5'b01100) begin tests_failed++; $display("[TB] FAIL error_entry: got busy/err/state=%b want %b", data_out_s[30:26], 5'b01100); end
    acks = 0;
    data_in_s = cmd(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 8'h11, 8'h22);
    repeat (6) begin
      @(posedge clk); #1;
      if (data_out_s[31] !== 1'b0) acks++;
    end
    data_in_s = 32'h0;
    tests_run++; if (acks !== 0 || data_out_s[28:26] !== 3'd4) begin tests_failed++; $display("[TB] FAIL error_req_ignored: got acks=%0d state=%0d want 0/4", acks, data_out_s[28:26]); end
    data_in_s = cmd(1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 8'h00, 8'h00);
    @(posedge clk); #1;
    data_in_s = 32'h0;
    tests_run++; if (data_out_s[30:26] !== 5'b00000) begin tests_failed++; $display("[TB] FAIL error_abort_clears: got %b want 0", data_out_s[30:26]); end
    repeat (3) @(posedge clk);
    #1;
    data_in_s = cmd(1'b0, 1'b1, 1'b0, 2'd1, 3'd2, 8'h00, 8'h00);
    @(posedge clk); #1;
    data_in_s = 32'h0;
    tests_run++; if (data_out_s[30:26] !== 5'b10001) begin tests_failed++; $display("[TB] FAIL error_max_dim_legal: got %b want %b", data_out_s[30:26], 5'b10001); end
    data_in_s = cmd(1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 8'h00, 8'h00);
    @(posedge clk); #1;
    data_in_s = 32'h0;
  endtask

  task automatic test_timeout();
    int lb, cyc, bad;
    randomize_model();
    cop_auto = 1'b0;
    do_start(3'($urandom), 2'd0);
    push_elements(0, 4, lb);
    tests_run++; if (data_out[28:26] !== 3'd2) begin tests_failed++; $display("[TB] FAIL timeout_process_entry: got %0d want 2", data_out[28:26]); end
`ifdef MATRIX_BRIDGE_TIMEOUT_EN
    wait_state(3'd4, 40, cyc);
    bad = 0;
    tests_run++; if (cyc !== TO) begin tests_failed++; $display("[TB] FAIL timeout_cycles: got %0d want %0d", cyc, TO); end
    tests_run++; if (data_out[30:29] !== 2'b01) begin tests_failed++; $display("[TB] FAIL timeout_error_flag: got busy/err=%b want 01", data_out[30:29]); end
`else
    cyc = 0; bad = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (data_out[28:26] !== 3'd2) bad++;
    end
    tests_run++; if (bad !== 0 || data_out[30:29] !== 2'b10) begin tests_failed++; $display("[TB] FAIL no_timeout_wait: got %0d cycles out of PROCESS busy/err=%b want 0/10", bad, data_out[30:29]); end
`endif
    data_in = cmd(1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 8'h00, 8'h00);
    @(posedge clk); #1;
    data_in = 32'h0;
    tests_run++; if (data_out[30:26] !== 5'b00000) begin tests_failed++; $display("[TB] FAIL timeout_abort: got %b want 0", data_out[30:26]); end
    cop_auto = 1'b1;
  endtask

  task automatic test_reset_in_send();
    int lb, ib, cyc;
    randomize_model();
    cop_auto = 1'b1; cop_delay = 3;
    do_start(3'($urandom), 2'd0);
    push_elements(0, 4, lb);
    wait_state(3'd3, 40, cyc);
    pull_results(2, lb, ib);
    tests_run++; if (data_out[28:26] !== 3'd3 || data_out[20:16] !== 5'd2 || data_out[7:0] !== model_r[2]) begin tests_failed++; $display("[TB] FAIL send_pre_reset: got state=%0d idx=%0d res=%h want 3/2/%h", data_out[28:26], data_out[20:16], data_out[7:0], model_r[2]); end
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++; if (data_out !== 32'h0) begin tests_failed++; $display("[TB] FAIL async_reset_data_out: got %h want 0", data_out); end
    tests_run++; if ((cop_a_flat | cop_b_flat) !== '0 || {cop_op, cop_size, cop_start} !== 6'd0) begin tests_failed++; $display("[TB] FAIL async_reset_storage: got %h ctrl=%b want 0", cop_a_flat | cop_b_flat, {cop_op, cop_size, cop_start}); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (data_out !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_release_idle: got %h want 0", data_out); end
  endtask

  initial begin
    reset_n   = 1'b0;
    data_in   = 32'h0;
    data_in_s = 32'h0;
    cop_done_s = 1'b0;
    cop_result_flat_s = '0;
    cop_auto  = 1'b1;
    cop_delay = 10;
    for (int i = 0; i < N; i++) begin
      model_a[i] = 8'h00; model_b[i] = 8'h00; model_r[i] = 8'h00; got_r[i] = 8'h00;
    end
    test_reset();
    test_basic();
    test_full_size();
    test_abort();
    test_oversize_error();
    test_timeout();
    test_reset_in_send();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/matrix_host_bridge.md
Name: matrix_host_bridge

Overview:
Parameterised HPS↔FPGA control bridge for the matrix coprocessor, the successor to the fixed 25-element single-edge controller. The block is a lightweight-bridge word-port slave on one side and drives a flattened coprocessor interface on the other. It adds:
- a full 4-phase req/ack handshake
- size-dependent element count (n·n)
- generic element width and matrix depth
- a status/error word
- synchronous abort

Parameters:
- ELEM_W, 8: element width in bits; legal range 1..8, because A and B share data_in[15:0].
- MAX_DIM, 5: maximum matrix dimension; storage holds MAX_DIM·MAX_DIM elements.
- IDX_W, 5: index width; must satisfy 2^IDX_W > MAX_DIM·MAX_DIM.
- TIMEOUT_CYCLES, 1024: coprocessor watchdog limit. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- data_in  in  32  HPS command word:
  - [ELEM_W-1:0] = A element
  - [8+ELEM_W-1:8] = B element
  - [18:16] = opcode
  - [20:19] = size code; n = code+2
  - [29] = abort
  - [30] = start
  - [31] = req
- data_out  out  32  status word:
  - [31] = ack
  - [30] = busy
  - [29] = error
  - [28:26] = state
  - [20:16] = index (low 5 bits)
  - [ELEM_W-1:0] = result element
  - all other bits 0
- cop_start  out  1  one-cycle start pulse to the coprocessor.
- cop_op  out  3  latched opcode.
- cop_size  out  2  latched size code.
- cop_a_flat  out  ELEM_W·MAX_DIM²  matrix A, element i at [i·ELEM_W +: ELEM_W].
- cop_b_flat  out  ELEM_W·MAX_DIM²  matrix B, same packing as A.
- cop_result_flat  in  ELEM_W·MAX_DIM²  coprocessor result.
- cop_done  in  1  coprocessor completion; level or pulse accepted.

Behaviour:
- Reset (reset_n=0): all state cleared.
  - state=IDLE, index=0.
  - A, B and result storage zeroed.
  - data_out=0, cop_start=0, cop_op=0, cop_size=0.
- req synchronisation:
  - data_in[31] passes through a 2-flop synchroniser, giving req_s.
  - Rising and falling edges are detected against a registered copy of req_s.
  - ack is registered. It asserts 3 clk after the req pin rises, and deasserts 3 clk after the pin falls.
- Abort: data_in[29]=1 in any state has top priority.
  - Next cycle: state=IDLE, index=0, ack=0, error=0.
  - Storage is held; the latched op and size are held.
- State codes: IDLE=0, RECEIVE=1, PROCESS=2, SEND=3, ERROR=4.
- IDLE:
  - Trigger: start=1 and req_s=0.
  - Latch cop_op and cop_size from data_in; compute count = n·n.
  - Zero A and B storage, set index=0.
  - If n > MAX_DIM, go to ERROR; otherwise go to RECEIVE.
  - start while req_s=1 is ignored.
- RECEIVE:
  - req rise: write A[index] and B[index] (low ELEM_W bits of each field), then ack←1.
  - req fall: ack←0, index++.
  - When index reaches count-1 and req falls: go to PROCESS, index←0, cop_start=1 for exactly one cycle.
  - opcode and size on data_in are ignored in this state.
- PROCESS:
  - cop_done=1: capture cop_result_flat into result storage, go to SEND, index=0.
  - cop_start is never re-pulsed while in PROCESS.
- SEND:
  - Output register: data_out[ELEM_W-1:0] = result[index] in SEND, and 0 in every other state.
  - req rise: ack←1. The result is guaranteed stable from the cycle ack rises until ack falls.
  - req fall: ack←0, index++.
  - After the fall for element count-1: go to IDLE.
  - If req_s=1 on entry to SEND, nothing happens until the next rising edge.
- ERROR:
  - error=1, ack=0.
  - The block stays in ERROR until abort or reset_n.
- busy=1 whenever state ∉ {IDLE, ERROR}.
- Simultaneous events:
  - abort beats every other event.
  - cop_done in the same cycle as a timeout: done wins.
  - A req edge in PROCESS, IDLE or ERROR is ignored; ack stays 0.
- Elements with index ≥ count read as 0 on cop_a_flat and cop_b_flat.

Optional Feature:
- Macro: MATRIX_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to PROCESS and increments each cycle.
  - When it reaches TIMEOUT_CYCLES without cop_done, the block goes to ERROR and sets error=1.
- Undefined:
  - No counter is built; PROCESS waits indefinitely for cop_done.
  - TIMEOUT_CYCLES is unused.

Test Plan:
1. Size code 0 (n=2), opcode 3; 4 req/ack cycles with A=1..4, B=5..8; coprocessor model asserts done 10 clk after cop_start → cop_a_flat low 32 bits = 0x04030201, upper bits 0; cop_start high exactly 1 clk; 4 SEND reads return the model result; state returns to 0.
2. Size code 3 (n=5) → exactly 25 receive handshakes before cop_start; a 26th req in PROCESS gets no ack.
3. Abort asserted mid-RECEIVE at index 7 → next cycle state=0, ack=0, index=0; a fresh start with size code 1 accepts 9 elements.
4. MAX_DIM=3, size code 2 (n=4) → state=4, error=1, busy=0; abort returns to IDLE with error=0.
5. MATRIX_BRIDGE_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, cop_done never asserted → ERROR exactly 16 clk after PROCESS entry; with the macro undefined, state stays 2 for 1000 clk.
6. reset_n low for 1 clk during SEND at index 2 → data_out=0 the same cycle it goes low (async); all storage 0; state=0 after release.
